// File: rtl/result_shift_network.sv
// Result staging/forwarding chain for the odd pipe: units inject at fixed stages,
// entries shift toward a single writeback register, with forwarding lookups and flush.
module result_shift_network #(
    parameter int unsigned                DATA_W      = 128,
    parameter int unsigned                ADDR_W      = 7,
    parameter int unsigned                DEPTH       = 7,
    parameter int unsigned                NUM_UNITS   = 3,
    parameter logic [4*NUM_UNITS-1:0]     UNIT_STAGE  = 12'h641,
    parameter int unsigned                NUM_RD      = 3,
    parameter int unsigned                FLUSH_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_UNITS-1:0]          unit_valid,
    input  logic [NUM_UNITS*DATA_W-1:0]   unit_data,
    input  logic [NUM_UNITS*ADDR_W-1:0]   unit_addr,
    input  logic                          flush,
    input  logic [NUM_RD*ADDR_W-1:0]      rd_addr,
    output logic [NUM_RD-1:0]             fwd_hit,
    output logic [NUM_RD*DATA_W-1:0]      fwd_data,
    output logic [DATA_W-1:0]             wb_data,
    output logic [ADDR_W-1:0]             wb_addr,
    output logic                          wb_write,
    output logic                          collision,
    output logic [$clog2(DEPTH+2)-1:0]    live_count
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 2);

    logic              stage_valid [1:DEPTH];
    logic [ADDR_W-1:0] stage_addr  [1:DEPTH];
    logic [DATA_W-1:0] stage_data  [1:DEPTH];

    logic              nxt_valid [1:DEPTH];
    logic [ADDR_W-1:0] nxt_addr  [1:DEPTH];
    logic [DATA_W-1:0] nxt_data  [1:DEPTH];
    logic              coll_event;

    // Next stage contents: flush kill, then injection (lowest unit wins), then shift.
    always_comb begin
        logic              inj_hit;
        logic              inj_multi;
        logic [ADDR_W-1:0] inj_addr;
        logic [DATA_W-1:0] inj_data;
        logic              sh_valid;
        logic [ADDR_W-1:0] sh_addr;
        logic [DATA_W-1:0] sh_data;
        coll_event = 1'b0;
        inj_hit    = 1'b0;
        inj_multi  = 1'b0;
        inj_addr   = '0;
        inj_data   = '0;
        sh_valid   = 1'b0;
        sh_addr    = '0;
        sh_data    = '0;
        for (int k = 1; k <= int'(DEPTH); k++) begin
            inj_hit   = 1'b0;
            inj_multi = 1'b0;
            inj_addr  = '0;
            inj_data  = '0;
            for (int i = 0; i < int'(NUM_UNITS); i++) begin
                if (unit_valid[i] && (UNIT_STAGE[4*i +: 4] == 4'(k))) begin
                    if (inj_hit) begin
                        inj_multi = 1'b1;
                    end else begin
                        inj_hit  = 1'b1;
                        inj_addr = unit_addr[ADDR_W*i +: ADDR_W];
                        inj_data = unit_data[DATA_W*i +: DATA_W];
                    end
                end
            end
            sh_valid = 1'b0;
            sh_addr  = '0;
            sh_data  = '0;
            if (k > 1) begin
                sh_valid = stage_valid[k-1];
                sh_addr  = stage_addr[k-1];
                sh_data  = stage_data[k-1];
            end
            if (flush && (k <= int'(FLUSH_DEPTH))) begin
                nxt_valid[k] = 1'b0;
                nxt_addr[k]  = '0;
                nxt_data[k]  = '0;
            end else if (inj_hit) begin
                nxt_valid[k] = 1'b1;
                nxt_addr[k]  = inj_addr;
                nxt_data[k]  = inj_data;
                if (inj_multi || sh_valid) begin
                    coll_event = 1'b1;
                end
            end else begin
                nxt_valid[k] = sh_valid;
                nxt_addr[k]  = sh_addr;
                nxt_data[k]  = sh_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                stage_valid[k] <= 1'b0;
                stage_addr[k]  <= '0;
                stage_data[k]  <= '0;
            end
            wb_write  <= 1'b0;
            wb_addr   <= '0;
            wb_data   <= '0;
            collision <= 1'b0;
        end else begin
            for (int k = 1; k <= int'(DEPTH); k++) begin
                stage_valid[k] <= nxt_valid[k];
                stage_addr[k]  <= nxt_addr[k];
                stage_data[k]  <= nxt_data[k];
            end
            wb_write  <= stage_valid[DEPTH];
            wb_addr   <= stage_addr[DEPTH];
            wb_data   <= stage_data[DEPTH];
            collision <= collision | coll_event;
        end
    end

    // Forwarding: wb is weakest, so it is applied first and overridden by older-to-younger stages.
    always_comb begin
        logic [ADDR_W-1:0] rd;
        rd       = '0;
        fwd_hit  = '0;
        fwd_data = '0;
        for (int j = 0; j < int'(NUM_RD); j++) begin
            rd = rd_addr[ADDR_W*j +: ADDR_W];
            if (wb_write && (wb_addr == rd)) begin
                fwd_hit[j]                  = 1'b1;
                fwd_data[DATA_W*j +: DATA_W] = wb_data;
            end
            for (int k = int'(DEPTH); k >= 1; k--) begin
                if (stage_valid[k] && (stage_addr[k] == rd)) begin
                    fwd_hit[j]                  = 1'b1;
                    fwd_data[DATA_W*j +: DATA_W] = stage_data[k];
                end
            end
        end
    end

    always_comb begin
        live_count = CNT_W'(wb_write);
        for (int k = 1; k <= int'(DEPTH); k++) begin
            live_count = live_count + CNT_W'(stage_valid[k]);
        end
    end

endmodule

// File: tb/tb_result_shift_network.sv
// Scoreboard bench for result_shift_network: default staging instance plus a
// same-stage-contention instance; writebacks are checked by a monitor process.
module tb_result_shift_network;

    localparam int unsigned DW = 128;
    localparam int unsigned AW = 7;
    localparam int unsigned NU = 3;
    localparam int unsigned NR = 3;
    localparam int unsigned CW = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic [NU-1:0]     a_uv, b_uv;
    logic [NU*DW-1:0]  a_ud, b_ud;
    logic [NU*AW-1:0]  a_ua, b_ua;
    logic              a_flush, b_flush;
    logic [NR*AW-1:0]  a_rd, b_rd;
    logic [NR-1:0]     a_fwd_hit, b_fwd_hit;
    logic [NR*DW-1:0]  a_fwd_data, b_fwd_data;
    logic [DW-1:0]     a_wb_data, b_wb_data;
    logic [AW-1:0]     a_wb_addr, b_wb_addr;
    logic              a_wb_write, b_wb_write;
    logic              a_coll, b_coll;
    logic [CW-1:0]     a_live, b_live;

    result_shift_network dut_a (
        .clk(clk), .reset(reset), .unit_valid(a_uv), .unit_data(a_ud), .unit_addr(a_ua),
        .flush(a_flush), .rd_addr(a_rd), .fwd_hit(a_fwd_hit), .fwd_data(a_fwd_data),
        .wb_data(a_wb_data), .wb_addr(a_wb_addr), .wb_write(a_wb_write),
        .collision(a_coll), .live_count(a_live)
    );

    result_shift_network #(.UNIT_STAGE(12'h444)) dut_b (
        .clk(clk), .reset(reset), .unit_valid(b_uv), .unit_data(b_ud), .unit_addr(b_ua),
        .flush(b_flush), .rd_addr(b_rd), .fwd_hit(b_fwd_hit), .fwd_data(b_fwd_data),
        .wb_data(b_wb_data), .wb_addr(b_wb_addr), .wb_write(b_wb_write),
        .collision(b_coll), .live_count(b_live)
    );

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        int            at;
    } wb_exp_t;

    wb_exp_t q_a[$];
    wb_exp_t q_b[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (edge %0d)", name, act, req, edges);
        end
    endtask

    task automatic clear_inputs();
        a_uv = '0; a_ud = '0; a_ua = '0; a_flush = 1'b0; a_rd = '0;
        b_uv = '0; b_ud = '0; b_ua = '0; b_flush = 1'b0; b_rd = '0;
    endtask

    // One cycle: inputs set after this call are consumed by the next rising edge.
    task automatic tick();
        @(negedge clk);
        clear_inputs();
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // lat = 0 means the entry must never reach writeback.
    task automatic inj_a(input int u, input logic [AW-1:0] addr, input logic [DW-1:0] data, input int lat);
        a_uv[u] = 1'b1;
        a_ua[u*AW +: AW] = addr;
        a_ud[u*DW +: DW] = data;
        if (lat > 0) q_a.push_back('{addr, data, edges + lat});
    endtask

    task automatic inj_b(input int u, input logic [AW-1:0] addr, input logic [DW-1:0] data, input int lat);
        b_uv[u] = 1'b1;
        b_ua[u*AW +: AW] = addr;
        b_ud[u*DW +: DW] = data;
        if (lat > 0) q_b.push_back('{addr, data, edges + lat});
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        fork
            begin : monitor
                wb_exp_t e;
                forever begin
                    @(negedge clk);
                    if (a_wb_write) begin
                        if (q_a.size() == 0) begin
                            check("a_wb_spurious", DW'(a_wb_write), DW'(0));
                        end else begin
                            e = q_a.pop_front();
                            check("a_wb_addr", DW'(a_wb_addr), DW'(e.addr));
                            check("a_wb_data", a_wb_data, e.data);
                            check("a_wb_edge", DW'(edges), DW'(e.at));
                        end
                    end
                    if (b_wb_write) begin
                        if (q_b.size() == 0) begin
                            check("b_wb_spurious", DW'(b_wb_write), DW'(0));
                        end else begin
                            e = q_b.pop_front();
                            check("b_wb_addr", DW'(b_wb_addr), DW'(e.addr));
                            check("b_wb_data", b_wb_data, e.data);
                            check("b_wb_edge", DW'(edges), DW'(e.at));
                        end
                    end
                end
            end
            begin : stimulus
                ticks(2);
                check("rst_wb_write", DW'(a_wb_write), DW'(0));
                check("rst_wb_addr", DW'(a_wb_addr), DW'(0));
                check("rst_wb_data", a_wb_data, DW'(0));
                check("rst_collision", DW'(a_coll), DW'(0));
                check("rst_live", DW'(a_live), DW'(0));
                check("rst_fwd_hit", DW'(a_fwd_hit), DW'(0));
                check("rst_b_live", DW'(b_live), DW'(0));
                reset = 1'b0;

                // reset while an entry is in flight
                tick(); inj_a(1, 7'd5, DW'(128'hAA), 0);
                tick(); check("mid_live_before", DW'(a_live), DW'(1));
                reset = 1'b1;
                tick(); reset = 1'b0;
                check("mid_live_after", DW'(a_live), DW'(0));
                check("mid_wb_write", DW'(a_wb_write), DW'(0));
                check("mid_collision", DW'(a_coll), DW'(0));
                ticks(8);

                // LS latency of 3 edges
                tick(); inj_a(2, 7'd9, DW'(128'h1234), 3);
                for (int c = 1; c <= 3; c++) begin
                    tick(); check("lat_live", DW'(a_live), DW'(1));
                end
                tick(); check("lat_single_cycle", DW'(a_wb_write), DW'(0));

                // injection over a shifting valid entry
                tick(); inj_a(0, 7'd3, DW'(128'h33), 0);
                ticks(2); check("coll_before", DW'(a_coll), DW'(0));
                tick(); inj_a(1, 7'd4, DW'(128'h44), 5);
                tick(); check("coll_set", DW'(a_coll), DW'(1));
                ticks(8);
                check("coll_sticky", DW'(a_coll), DW'(1));
                check("coll_drained", DW'(a_live), DW'(0));
                reset = 1'b1;
                tick(); reset = 1'b0;
                check("coll_cleared", DW'(a_coll), DW'(0));

                // forwarding priority
                tick(); inj_a(0, 7'd7, DW'(128'h11), 8);
                tick();
                tick(); inj_a(0, 7'd7, DW'(128'h22), 8);
                tick(); a_rd = {7'd3, 7'd8, 7'd7}; #1;
                check("fwd0_hit", DW'(a_fwd_hit[0]), DW'(1));
                check("fwd0_data", a_fwd_data[0 +: DW], DW'(128'h22));
                check("fwd1_hit", DW'(a_fwd_hit[1]), DW'(0));
                check("fwd1_data", a_fwd_data[DW +: DW], DW'(0));
                check("fwd2_hit", DW'(a_fwd_hit[2]), DW'(0));
                ticks(5); a_rd = {7'd0, 7'd0, 7'd7}; #1;
                check("fwd_stage_over_wb_hit", DW'(a_fwd_hit[0]), DW'(1));
                check("fwd_stage_over_wb_data", a_fwd_data[0 +: DW], DW'(128'h22));
                ticks(2); a_rd = {7'd0, 7'd0, 7'd7}; #1;
                check("fwd_wb_hit", DW'(a_fwd_hit[0]), DW'(1));
                check("fwd_wb_data", a_fwd_data[0 +: DW], DW'(128'h22));
                check("fwd_wb_live", DW'(a_live), DW'(1));
                tick();

                // flush kills young stages only
                tick(); inj_a(0, 7'd2, DW'(128'h55), 0); inj_a(1, 7'd6, DW'(128'h66), 5);
                tick(); a_flush = 1'b1;
                tick();
                check("flush_live", DW'(a_live), DW'(1));
                check("flush_coll", DW'(a_coll), DW'(0));
                a_flush = 1'b1; inj_a(0, 7'd10, DW'(128'hEE), 0);
                tick();
                check("flush_inj_live", DW'(a_live), DW'(1));
                check("flush_inj_coll", DW'(a_coll), DW'(0));
                ticks(4);
                check("flush_end_live", DW'(a_live), DW'(0));
                check("flush_end_coll", DW'(a_coll), DW'(0));

                // same-stage contention on the all-stage-4 instance
                tick(); inj_b(0, 7'd1, DW'(128'h101), 5); inj_b(2, 7'd2, DW'(128'h202), 0);
                tick(); check("same_stage_coll", DW'(b_coll), DW'(1));
                check("same_stage_live", DW'(b_live), DW'(1));
                ticks(6);
                check("same_stage_drained", DW'(b_live), DW'(0));

                check("q_a_empty", DW'(q_a.size()), DW'(0));
                check("q_b_empty", DW'(q_b.size()), DW'(0));
            end
        join_any
        disable fork;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_shift_network.md
Name: result_shift_network

Overview:
- Parametrised result staging/forwarding network for the odd pipe. Generalises the fixed 7-entry perm/LS/branch staging chain.
- NUM_UNITS execution units each inject a result at a configurable stage of a DEPTH-stage shift chain. The chain drains into a single register-file writeback port.
- New over the previous generation: multi-port forwarding lookup, branch flush of young stages, collision detection and a live-entry count.

Parameters:
DATA_W, 128, result width
ADDR_W, 7, register address width
DEPTH, 7, number of staging stages (1..DEPTH); writeback register follows stage DEPTH
NUM_UNITS, 3, number of injecting units
UNIT_STAGE, 12'h641, packed 4-bit fields; field i = bits [4i+3:4i] = injection stage of unit i (default: unit0=1 branch, unit1=4 perm, unit2=6 LS); each field must be in 1..DEPTH
NUM_RD, 3, forwarding lookup ports
FLUSH_DEPTH, 2, stages 1..FLUSH_DEPTH cleared by flush

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
unit_valid  in  NUM_UNITS  unit i presents a register-writing result this cycle
unit_data  in  NUM_UNITS*DATA_W  result of unit i, slice i
unit_addr  in  NUM_UNITS*ADDR_W  destination register of unit i, slice i
flush  in  1  branch-taken kill of young entries
rd_addr  in  NUM_RD*ADDR_W  source addresses to look up
fwd_hit  out  NUM_RD  lookup j matched a valid entry
fwd_data  out  NUM_RD*DATA_W  forwarded value for lookup j (0 when no hit)
wb_data  out  DATA_W  writeback value
wb_addr  out  ADDR_W  writeback register
wb_write  out  1  writeback enable
collision  out  1  sticky: an injection overwrote a valid entry
live_count  out  $clog2(DEPTH+2)  number of valid entries (stages plus wb register)

Behaviour:
- State per stage k: valid, addr, data. Reset: all stage valid/addr/data = 0; wb_data/wb_addr/wb_write = 0; collision = 0. Reset overrides flush and injection.
- Each clock, stage k:
  - Loads from the injecting unit if one targets stage k with unit_valid = 1.
  - Otherwise loads from stage k-1.
  - Stage 1 loads zeros (valid = 0) when nothing is injected there.
- wb register <= stage DEPTH every clock. Latency: unit injecting at stage s reaches wb_write = 1 at exactly DEPTH-s+2 edges after presentation (default LS: 3, perm: 5, branch: 8).
- Several units targeting the same stage in one cycle: lowest unit index wins; collision set.
- Injection into stage k while stage k-1 holds a valid entry: injected entry wins, the shifted entry is dropped, collision set.
- collision stays set until reset.
- flush = 1:
  - Entries shifting into stages 1..FLUSH_DEPTH are written with valid = 0. Injections into those stages are discarded, with no collision.
  - Stages above FLUSH_DEPTH and the wb register shift normally.
  - Flush lasts one cycle per assertion.
- Invalid entries carry addr = 0 and data = 0.
- Forwarding is purely combinational from current stage and wb registers:
  - Candidates: valid stages and wb (when wb_write = 1) with addr == rd_addr[j].
  - Priority: lowest stage number first, wb register last.
  - Same-cycle unit inputs are not visible to lookups.
- live_count = popcount of stage valids + wb_write, combinational.

Test Plan:
- Reset mid-flight: inject unit1 addr 5 data 0xAA, assert reset next cycle -> all outputs 0, live_count 0, collision 0; no later wb_write.
- Latency: unit2 valid, addr 9, data 0x1234 at cycle 0 -> wb_write = 1, wb_addr 9, wb_data 0x1234 exactly at edge 3, single cycle; live_count = 1 throughout edges 1..3.
- Collision: unit0 addr 3 at cycle 0, unit1 addr 4 at cycle 3 (unit0 entry then in stage 3, shifting to 4) -> only addr 4 reaches wb at cycle 8; collision = 1 and remains 1.
- Forwarding priority: addr 7 data 0x11 injected by unit0, two cycles later addr 7 data 0x22 by unit0; rd_addr[0] = 7 -> fwd_hit[0] = 1, fwd_data = 0x22; rd_addr[1] = 8 -> fwd_hit[1] = 0, data 0.
- Flush: unit0 addr 2 at cycle 0, flush at cycle 1 -> entry killed (no wb_write), collision 0. Unit1 addr 6 entry injected at cycle 0 still writes back at edge 5.
- Same-stage contention (UNIT_STAGE = 12'h444): units 0 and 2 both valid, addrs 1 and 2 -> only addr 1 written back; collision = 1.
